// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fft_pkg
// Description : Shared defaults and width helpers for the FFT datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int c_BW_DEFAULT   = 16;   // I/Q component width
    localparam int c_TW_DEFAULT   = 12;   // twiddle component width
    localparam int c_N_PT_DEFAULT = 64;   // twiddle table depth
    localparam int c_SAT_CNT_W    = 16;   // saturation event counter width

    // Full-precision width of one BW x TW signed multiply.
    function automatic int prod_width(input int bw, input int tw);
        return bw + tw;
    endfunction

    // Accumulator width: sum of two products plus room for the rounding offset.
    function automatic int acc_width(input int bw, input int tw);
        return bw + tw + 2;
    endfunction

    // Right shift that removes the twiddle unity scaling of 2^(TW-2).
    function automatic int round_shift(input int tw);
        return tw - 2;
    endfunction

    // Round-to-nearest of a real value; only used to build the twiddle table.
    function automatic int round_real(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_rom.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_rom
// Description : Combinational twiddle table W(k) = round(2^(TW-2)*exp(-j*pi*k/N_PT)).
//               Entries are computed at elaboration, so every supported N_PT/TW
//               pair gets its own table without a separate generated file.
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_rom
    import fft_pkg::*;
#(
    parameter  int TW    = c_TW_DEFAULT,
    parameter  int N_PT  = c_N_PT_DEFAULT,
    localparam int CNT_W = $clog2(N_PT)
)(
    input  logic        [CNT_W-1:0] i_idx,
    output logic signed [TW-1:0]    o_wr,
    output logic signed [TW-1:0]    o_wi
);

    localparam real c_PI    = 3.14159265358979323846;
    localparam real c_UNITY = 2.0 ** (TW - 2);

    logic signed [TW-1:0] w_wr_tab [N_PT];
    logic signed [TW-1:0] w_wi_tab [N_PT];

    for (genvar gi = 0; gi < N_PT; gi++) begin : g_entry
        localparam real c_ANG = c_PI * gi / N_PT;
        localparam int  c_WR  = round_real(c_UNITY * $cos(c_ANG));
        localparam int  c_WI  = round_real(-c_UNITY * $sin(c_ANG));
        assign w_wr_tab[gi] = TW'(c_WR);
        assign w_wi_tab[gi] = TW'(c_WI);
    end

    assign o_wr = w_wr_tab[i_idx];
    assign o_wi = w_wi_tab[i_idx];

endmodule
`default_nettype wire

// File: rtl/twiddle_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_mult_pipe
// Description : 3-stage complex multiply of a streaming sample by a table
//               twiddle, with rounding, saturation and a saturation counter.
//               A single global enable stalls the whole pipe on backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_mult_pipe
    import fft_pkg::*;
#(
    parameter  int BW    = c_BW_DEFAULT,
    parameter  int TW    = c_TW_DEFAULT,
    parameter  int N_PT  = c_N_PT_DEFAULT,
    parameter  int TAG_W = 8,
    localparam int CNT_W = $clog2(N_PT)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BW-1:0]   in_re,
    input  logic signed [BW-1:0]   in_im,
    input  logic        [CNT_W-1:0] in_k,
    input  logic                   in_inv,
    input  logic        [TAG_W-1:0] in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BW-1:0]   out_re,
    output logic signed [BW-1:0]   out_im,
    output logic        [TAG_W-1:0] out_tag,
    output logic                   out_sat,
    output logic [c_SAT_CNT_W-1:0] sat_cnt,
    input  logic                   sat_clr
);

    localparam int c_PROD_W = prod_width(BW, TW);
    localparam int c_ACC_W  = acc_width(BW, TW);
    localparam int c_SHIFT  = round_shift(TW);

    localparam logic signed [c_ACC_W-1:0] c_RND = c_ACC_W'(2 ** (TW - 3));
    localparam logic signed [c_ACC_W-1:0] c_MAX = c_ACC_W'((2 ** (BW - 1)) - 1);
    localparam logic signed [c_ACC_W-1:0] c_MIN = ~c_MAX;

    // Scale down by the twiddle unity and clamp; result is {clamped, value}.
    function automatic logic [BW:0] scale_clamp(input logic signed [c_ACC_W-1:0] v);
        logic signed [c_ACC_W-1:0] sh;
        sh = v >>> c_SHIFT;
        if (sh > c_MAX) begin
            return {1'b1, c_MAX[BW-1:0]};
        end
        if (sh < c_MIN) begin
            return {1'b1, c_MIN[BW-1:0]};
        end
        return {1'b0, sh[BW-1:0]};
    endfunction

    logic                       w_en;
    logic signed [TW-1:0]       w_rom_wr;
    logic signed [TW-1:0]       w_rom_wi;
    logic signed [TW-1:0]       w_wi_eff;

    logic                       r_s1_valid;
    logic signed [BW-1:0]       r_s1_re;
    logic signed [BW-1:0]       r_s1_im;
    logic signed [TW-1:0]       r_s1_wr;
    logic signed [TW-1:0]       r_s1_wi;
    logic        [TAG_W-1:0]    r_s1_tag;

    logic signed [c_PROD_W-1:0] w_p_ar;
    logic signed [c_PROD_W-1:0] w_p_bi;
    logic signed [c_PROD_W-1:0] w_p_ai;
    logic signed [c_PROD_W-1:0] w_p_br;

    logic                       r_s2_valid;
    logic signed [c_PROD_W-1:0] r_s2_ar;
    logic signed [c_PROD_W-1:0] r_s2_bi;
    logic signed [c_PROD_W-1:0] r_s2_ai;
    logic signed [c_PROD_W-1:0] r_s2_br;
    logic        [TAG_W-1:0]    r_s2_tag;

    logic signed [c_ACC_W-1:0]  w_acc_re;
    logic signed [c_ACC_W-1:0]  w_acc_im;
    logic        [BW:0]         w_res_re;
    logic        [BW:0]         w_res_im;

    logic                       r_out_valid;
    logic signed [BW-1:0]       r_out_re;
    logic signed [BW-1:0]       r_out_im;
    logic        [TAG_W-1:0]    r_out_tag;
    logic                       r_out_sat;
    logic [c_SAT_CNT_W-1:0]     r_sat_cnt;

    // Every stage, valid bits included, moves only when the output slot frees up.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    twiddle_rom #(
        .TW   (TW),
        .N_PT (N_PT)
    ) u_twiddle_rom (
        .i_idx (in_k),
        .o_wr  (w_rom_wr),
        .o_wi  (w_rom_wi)
    );

    // Inverse transform uses the conjugate twiddle. The table never holds
    // -2^(TW-1), so the negation cannot overflow.
    assign w_wi_eff = in_inv ? -w_rom_wi : w_rom_wi;

    // S1: capture the accepted sample together with its twiddle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_wr    <= '0;
            r_s1_wi    <= '0;
            r_s1_tag   <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_re    <= in_re;
            r_s1_im    <= in_im;
            r_s1_wr    <= w_rom_wr;
            r_s1_wi    <= w_wi_eff;
            r_s1_tag   <= in_tag;
        end
    end

    assign w_p_ar = c_PROD_W'(r_s1_re) * c_PROD_W'(r_s1_wr);
    assign w_p_bi = c_PROD_W'(r_s1_im) * c_PROD_W'(r_s1_wi);
    assign w_p_ai = c_PROD_W'(r_s1_re) * c_PROD_W'(r_s1_wi);
    assign w_p_br = c_PROD_W'(r_s1_im) * c_PROD_W'(r_s1_wr);

    // S2: register the four full-precision partial products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_ar    <= '0;
            r_s2_bi    <= '0;
            r_s2_ai    <= '0;
            r_s2_br    <= '0;
            r_s2_tag   <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_ar    <= w_p_ar;
            r_s2_bi    <= w_p_bi;
            r_s2_ai    <= w_p_ai;
            r_s2_br    <= w_p_br;
            r_s2_tag   <= r_s1_tag;
        end
    end

    // Rounding offset is folded into the sum so one adder tree does both.
    assign w_acc_re = c_ACC_W'(r_s2_ar) - c_ACC_W'(r_s2_bi) + c_RND;
    assign w_acc_im = c_ACC_W'(r_s2_ai) + c_ACC_W'(r_s2_br) + c_RND;
    assign w_res_re = scale_clamp(w_acc_re);
    assign w_res_im = scale_clamp(w_acc_im);

    // S3: register the rounded, saturated result and its saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_tag   <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            r_out_re    <= w_res_re[BW-1:0];
            r_out_im    <= w_res_im[BW-1:0];
            r_out_tag   <= r_s2_tag;
            r_out_sat   <= w_res_re[BW] | w_res_im[BW];
        end
    end

    // Count saturated outputs as they are handed off; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_sat && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + c_SAT_CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_tag   = r_out_tag;
    assign out_sat   = r_out_sat;
    assign sat_cnt   = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_mult_pipe
// Description : Self-checking bench for twiddle_mult_pipe with a scoreboard
//               fed from an independent floating-point twiddle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_mult_pipe;

    localparam int  BW    = 16;
    localparam int  TW    = 12;
    localparam int  N_PT  = 64;
    localparam int  TAG_W = 8;
    localparam int  CNT_W = 6;
    localparam real PI    = 3.14159265358979323846;

    logic                     clk       = 1'b0;
    logic                     rst       = 1'b1;
    logic                     in_valid  = 1'b0;
    logic                     in_inv    = 1'b0;
    logic                     out_ready = 1'b1;
    logic                     sat_clr   = 1'b0;
    logic signed [BW-1:0]     in_re     = '0;
    logic signed [BW-1:0]     in_im     = '0;
    logic        [CNT_W-1:0]  in_k      = '0;
    logic        [TAG_W-1:0]  in_tag    = '0;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_sat;
    logic signed [BW-1:0]     out_re;
    logic signed [BW-1:0]     out_im;
    logic        [TAG_W-1:0]  out_tag;
    logic        [15:0]       sat_cnt;

    int          checks   = 0;
    int          failures = 0;
    int          popped   = 0;
    logic [40:0] sb [$];
    bit          got_out;
    bit          accepted;
    bit          stall_prev = 1'b0;
    logic [40:0] last_out;
    logic [40:0] prev_out;

    twiddle_mult_pipe #(
        .BW    (BW),
        .TW    (TW),
        .N_PT  (N_PT),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_k      (in_k),
        .in_inv    (in_inv),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_tag   (out_tag),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    // Golden model: returns {sat, tag, re, im}.
    function automatic logic [40:0] model(input logic signed [BW-1:0] a, input logic signed [BW-1:0] b,
                                          input int k, input bit inv, input logic [TAG_W-1:0] tag);
        real    ang;
        int     wr;
        int     wi;
        longint pr;
        longint pim;
        longint lim_hi;
        longint lim_lo;
        bit     s;
        ang    = PI * k / N_PT;
        wr     = rnd(1024.0 * $cos(ang));
        wi     = rnd(-1024.0 * $sin(ang));
        if (inv) wi = -wi;
        pr     = (longint'(a) * wr - longint'(b) * wi + 512) >>> 10;
        pim    = (longint'(a) * wi + longint'(b) * wr + 512) >>> 10;
        lim_hi = 32767;
        lim_lo = -32768;
        s      = 1'b0;
        if (pr > lim_hi) begin pr = lim_hi; s = 1'b1; end
        if (pr < lim_lo) begin pr = lim_lo; s = 1'b1; end
        if (pim > lim_hi) begin pim = lim_hi; s = 1'b1; end
        if (pim < lim_lo) begin pim = lim_lo; s = 1'b1; end
        return {s, tag, 16'(pr), 16'(pim)};
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp_v);
        end
    endtask

    // One clock: sample at negedge (scoreboard pop/push, hold check), return at posedge+1.
    task automatic tick();
        logic [40:0] obs;
        logic [40:0] exp_v;
        @(negedge clk);
        obs      = {out_sat, out_tag, out_re, out_im};
        got_out  = 1'b0;
        accepted = 1'b0;
        if (stall_prev) check("hold_stable", 64'(obs), 64'(prev_out));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_out observed=0x%0h expected=no_output", obs);
            end else begin
                exp_v = sb.pop_front();
                popped++;
                check("sb_out", 64'(obs), 64'(exp_v));
                got_out  = 1'b1;
                last_out = obs;
            end
        end
        stall_prev = out_valid && !out_ready;
        prev_out   = obs;
        if (in_valid && in_ready) begin
            sb.push_back(model(in_re, in_im, int'(in_k), in_inv, in_tag));
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Send one sample with out_ready high and check latency and exact result.
    task automatic run_single(input string name, input logic signed [BW-1:0] a, input logic signed [BW-1:0] b,
                              input int k, input bit inv, input logic [TAG_W-1:0] tag,
                              input logic signed [BW-1:0] er, input logic signed [BW-1:0] ei, input bit es);
        int lat;
        in_valid  = 1'b1;
        in_re     = a;
        in_im     = b;
        in_k      = CNT_W'(k);
        in_inv    = inv;
        in_tag    = tag;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!got_out && lat < 20);
        check({name, "_lat"}, 64'(lat), 64'(3));
        check({name, "_val"}, 64'(last_out), 64'({es, tag, er, ei}));
    endtask

    initial begin
        int i;
        int cyc;
        int p0;
        int sent;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'({out_sat, out_tag, out_re, out_im}), 64'(0));
        check("rst_sat_cnt", 64'(sat_cnt), 64'(0));
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed products
        run_single("k0",     16'sd1000, 16'sd500, 0, 1'b0, 8'h11, 16'sd1000, 16'sd500, 1'b0);
        run_single("k32",    16'sd1000, 16'sd0,  32, 1'b0, 8'h22, 16'sd0, -16'sd1000, 1'b0);
        run_single("k32inv", 16'sd1000, 16'sd0,  32, 1'b1, 8'h23, 16'sd0,  16'sd1000, 1'b0);
        run_single("k16sat", -16'sd32768, -16'sd32768, 16, 1'b0, 8'h33, -16'sd32768, 16'sd0, 1'b1);
        check("sat_cnt_inc", 64'(sat_cnt), 64'(1));

        // Saturated output parked at the head, then cleared on the same cycle it is taken
        in_valid = 1'b1; in_re = -16'sd32768; in_im = -16'sd32768; in_k = 6'd16; in_inv = 1'b0;
        in_tag = 8'h34; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("parked_valid", 64'(out_valid), 64'(1));
        check("parked_in_ready", 64'(in_ready), 64'(0));
        sat_clr = 1'b1; out_ready = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_clr_wins", 64'(sat_cnt), 64'(0));
        run_single("k16sat2", -16'sd32768, -16'sd32768, 16, 1'b0, 8'h35, -16'sd32768, 16'sd0, 1'b1);
        check("sat_cnt_again", 64'(sat_cnt), 64'(1));
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_clr", 64'(sat_cnt), 64'(0));

        // Back-to-back stream k=0..63 with a 5-cycle downstream stall
        i = 0; cyc = 0; p0 = popped;
        while (i < 64 && cyc < 500) begin
            in_valid  = 1'b1;
            in_re     = 16'($urandom);
            in_im     = 16'($urandom);
            in_k      = CNT_W'(i);
            in_inv    = 1'b0;
            in_tag    = TAG_W'(i);
            out_ready = !(cyc >= 20 && cyc < 25);
            #1;
            if (!out_ready) check("stall_in_ready", 64'(in_ready), 64'(0));
            tick();
            if (accepted) i++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 50) begin tick(); cyc++; end
        check("stream_count", 64'(popped - p0), 64'(64));
        check("stream_drained", 64'(sb.size()), 64'(0));

        // Reset with three samples in flight
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_re = 16'($urandom); in_im = 16'($urandom);
            in_k = CNT_W'(j + 5); in_tag = TAG_W'(8'hA0 + j);
            tick();
        end
        in_valid = 1'b0;
        check("inflight_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'(0));
        sb.delete();
        stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        repeat (6) begin
            tick();
            check("no_stale", 64'(out_valid), 64'(0));
        end

        // Randomized traffic with random backpressure and bubbles
        sent = 0; cyc = 0; p0 = popped;
        while (sent < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 7) != 0);
            in_re     = 16'($urandom);
            in_im     = 16'($urandom);
            in_k      = CNT_W'($urandom);
            in_inv    = 1'($urandom);
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (accepted) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 50) begin tick(); cyc++; end
        check("rand_sent", 64'(sent), 64'(10000));
        check("rand_count", 64'(popped - p0), 64'(10000));
        check("rand_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
